// File: rtl/adder_pkg.sv
// Shared constants and vector types for the registered ripple-carry adder.
// Optional macro OVERFLOW_FLAG_EN is consumed by the top level only.
package adder_pkg;

  localparam int ADDER_WIDTH = 4;

  typedef logic [ADDER_WIDTH-1:0] operand_t;
  typedef logic [ADDER_WIDTH:0]   result_t;

endpackage : adder_pkg

// File: rtl/full_adder_1bit.sv
// Single-bit full-adder cell in dataflow style; one link of the ripple chain.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop_s;

  assign prop_s = a ^ b;
  assign s      = prop_s ^ cin;
  assign cout   = (a & b) | (cin & prop_s);

endmodule : full_adder_1bit

// File: rtl/ripple_adder_4bit.sv
// Registered ripple-carry adder: {carry_out, sum} = a + b + carry_in, one-cycle latency.
// Define OVERFLOW_FLAG_EN to add a registered two's-complement overflow output.
module ripple_adder_4bit #(
  parameter int WIDTH = adder_pkg::ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
`ifdef OVERFLOW_FLAG_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  import adder_pkg::*;

  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] s_s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             valid_r;

  assign c_s[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_1bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c_s[i]),
      .s    (s_s[i]),
      .cout (c_s[i+1])
    );
  end

  // Result registers load only on in_valid, so unsampled inputs never reach outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
    end else if (in_valid) begin
      sum_r   <= s_s;
      carry_r <= c_s[WIDTH];
    end else begin
      sum_r   <= sum_r;
      carry_r <= carry_r;
    end
  end

  // Valid flag marks the cycle a fresh result appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (in_valid) begin
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic ovf_r;

  // Signed overflow: carries into and out of the MSB disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (in_valid) begin
      ovf_r <= c_s[WIDTH] ^ c_s[WIDTH-1];
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign overflow = ovf_r;
`endif

  assign sum       = sum_r;
  assign carry_out = carry_r;
  assign out_valid = valid_r;

endmodule : ripple_adder_4bit

// File: tb/tb_ripple_adder_4bit.sv
// Scoreboard bench for ripple_adder_4bit: driver pushes expected results, monitor pops on out_valid.
module tb_ripple_adder_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       carry_in;
  logic       out_valid;
  logic [3:0] sum;
  logic       carry_out;
`ifdef OVERFLOW_FLAG_EN
  logic       overflow;
`endif

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ripple_adder_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .sum       (sum),
`ifdef OVERFLOW_FLAG_EN
    .overflow  (overflow),
`endif
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_vec(input int av, input int bv, input int cv,
                           input int es, input int ec, input int eo);
    exp_t e;
    @(negedge clk);
    a        = 4'(av);
    b        = 4'(bv);
    carry_in = 1'(cv);
    in_valid = 1'b1;
    e.sum  = 4'(es);
    e.cout = 1'(ec);
    e.ovf  = 1'(eo);
    sb.push_back(e);
  endtask

  // Reference model: exact integer sum, signed overflow from operand/result signs.
  task automatic drive_calc(input int av, input int bv, input int cv);
    int r;
    int ovf;
    r   = av + bv + cv;
    ovf = (((av >> 3) & 1) == ((bv >> 3) & 1)) && ((((r >> 3) & 1)) != ((av >> 3) & 1));
    drive_vec(av, bv, cv, r % 16, r / 16, ovf);
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: out_valid=1 with empty scoreboard, sum=%0d at %0t", sum, $time);
        end else begin
          e = sb.pop_front();
          check_val("sum", 8'(sum), 8'(e.sum));
          check_val("carry_out", 8'(carry_out), 8'(e.cout));
`ifdef OVERFLOW_FLAG_EN
          check_val("overflow", 8'(overflow), 8'(e.ovf));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 4'b1010;
    b        = 4'b0101;
    carry_in = 1'b0;
    #1;
    check_val("rst_sum", 8'(sum), 8'd0);
    check_val("rst_cout", 8'(carry_out), 8'd0);
    check_val("rst_valid", 8'(out_valid), 8'd0);
`ifdef OVERFLOW_FLAG_EN
    check_val("rst_ovf", 8'(overflow), 8'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold_sum", 8'(sum), 8'd0);
    check_val("rst_hold_valid", 8'(out_valid), 8'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_valid", 8'(out_valid), 8'd0);

    // Directed vectors with hand-computed results.
    drive_vec(3, 2, 1, 6, 0, 0);
    drive_vec(15, 1, 0, 0, 1, 0);
    drive_vec(15, 15, 1, 15, 1, 0);
    drive_vec(7, 1, 0, 8, 0, 1);
    drive_vec(8, 8, 0, 0, 1, 1);
    drive_vec(2, 3, 0, 5, 0, 0);
    drive_vec(3, 3, 1, 7, 0, 0);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        drive_calc(i, j, i % 2);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++)
          drive_calc(i, j, k);

    // Hold: 4+5 = 9, then idle with zero operands.
    drive_vec(4, 5, 0, 9, 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    carry_in = 1'b1;
    @(posedge clk);
    #1;
    check_val("hold_sum", 8'(sum), 8'd9);
    check_val("hold_valid", 8'(out_valid), 8'd0);
`ifdef OVERFLOW_FLAG_EN
    check_val("hold_ovf", 8'(overflow), 8'd1);
`endif
    @(posedge clk);
    #1;
    check_val("hold_sum2", 8'(sum), 8'd9);

    // Mid-stream reset: a captured 31 clears, the in-flight vector is discarded.
    drive_vec(15, 15, 1, 15, 1, 0);
    drive_vec(6, 6, 0, 12, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_sum", 8'(sum), 8'd0);
    check_val("mid_rst_cout", 8'(carry_out), 8'd0);
    check_val("mid_rst_valid", 8'(out_valid), 8'd0);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_rst_hold_sum", 8'(sum), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    drive_vec(1, 2, 0, 3, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_val("sb_drained", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ripple_adder_4bit

// File: doc/ripple_adder_4bit.md
Name: ripple_adder_4bit

Overview:
- Registered 4-bit ripple-carry adder: sum = a + b + carry_in, with carry-out.
- The carry chain is built from single-bit full-adder cells in dataflow style.
- The result is captured in an output register on the single clock, giving a one-cycle latency.
- Used as a leaf arithmetic block in datapaths and as a reference adder for verification.

Parameters:
- WIDTH, 4, operand/sum width in bits. The design is parameterised, but 4 is the only value signed off.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands on a/b/carry_in are valid this cycle
- a  input  WIDTH  unsigned operand A
- b  input  WIDTH  unsigned operand B
- carry_in  input  1  carry into bit 0
- out_valid  output  1  sum/carry_out hold a new result
- sum  output  WIDTH  registered sum bits [WIDTH-1:0]
- carry_out  output  1  registered carry out of MSB
- overflow  output  1  signed overflow (present only with OVERFLOW_FLAG_EN)

Behaviour:
- Carry chain:
  - c[0] = carry_in.
  - For each bit i: s[i] = a[i]^b[i]^c[i], and c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])).
  - carry_out = c[WIDTH].
- Arithmetic:
  - {carry_out, sum} = a + b + carry_in, exact and unsigned, with WIDTH+1 result bits.
  - The result range is 0..2^(WIDTH+1)-1; at WIDTH=4 the maximum is 31 (15+15+1 gives sum=15, carry_out=1).
  - Wrap-around: sum is the low WIDTH bits only; carry_out carries the 2^WIDTH weight.
- Timing:
  - On a rising clk with in_valid=1: sum, carry_out (and overflow) load the combinational result, and out_valid<=1.
  - On a rising clk with in_valid=0: sum, carry_out (and overflow) hold their previous values, and out_valid<=0.
  - Latency is 1 cycle. Throughput is one operation per cycle with no backpressure, so no ready signal.
- Reset:
  - While rst=1, asynchronously and regardless of clk: sum=0, carry_out=0, out_valid=0, overflow=0.
  - Asserting rst mid-operation discards the in-flight result.
  - The first capture after rst deasserts is on the next rising clk with in_valid=1.
- X-handling: inputs are not sampled when in_valid=0, so X on a/b/carry_in in that case must not reach the outputs.
- No internal state other than the output registers.

Optional Feature:
- Macro OVERFLOW_FLAG_EN.
- When defined:
  - Adds the overflow output, computed as c[WIDTH]^c[WIDTH-1] (two's-complement overflow of a + b + carry_in).
  - overflow is registered alongside sum, follows the same in_valid hold rule, and resets to 0.
- When undefined: the overflow port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (adder_pkg) holds:
  - the ADDER_WIDTH=4 default constant;
  - a typedef for the operand vector;
  - a typedef for the result vector (WIDTH+1 bits).
- One sub-module is natural: full_adder_1bit.
  - Ports: a, b, cin, s, cout.
  - Purely combinational dataflow.
  - Instantiated WIDTH times with a generate loop to form the ripple chain; the top level adds the registers and valid logic.

Test Plan:
- Reset: assert rst with a=4'b1010, b=4'b0101, in_valid=1. Required: sum=0, carry_out=0, out_valid=0 immediately without a clock edge, held until after deassert.
- Basic: a=3, b=2, carry_in=1, in_valid=1. Required one clk later: sum=6, carry_out=0, out_valid=1.
- Wrap-around:
  - a=15, b=1, carry_in=0 gives sum=0, carry_out=1.
  - a=15, b=15, carry_in=1 gives sum=15, carry_out=1.
- Sweep: a,b in 0..3 with carry_in=a%2, one vector per cycle. Required: each result matches a+b+carry_in one cycle later (e.g. a=3, b=3, cin=1 gives sum=7). Then repeat exhaustively over all 512 combinations against a reference model.
- Hold/valid: a result of 9, then in_valid=0 with a=0, b=0. Required: sum stays 9, out_valid drops to 0. Also assert rst mid-stream and check the outputs clear asynchronously.
- With OVERFLOW_FLAG_EN:
  - a=7, b=1, cin=0 gives overflow=1, sum=8.
  - a=8, b=8 gives overflow=1, sum=0, carry_out=1.
  - a=2, b=3 gives overflow=0.
